verinject_ff_injector_seu: RTL and testbench

Stateful fault injector placed on the output of an instrumented flip-flop word by the verinject transformation. It decodes the global `verinject__injector_state` against its bit range and latches a fault mask: a single- or multi-bit upset of adjacent bits. The mask is then held according to a selectable fault model: a transient held for a fixed number of cycles, an upset cleared by the next write, or stuck until reset. This is the successor to the purely combinational single-bit injector; fault lifetime becomes a function of time and of writes to the word.

---
 rtl/verinject_ff_injector_seu.sv | 144 ++++++++++++++
 tb/tb_verinject_ff_injector_seu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/verinject_ff_injector_seu.sv
// Stateful SEU/MBU fault injector for one instrumented flip-flop word.
// Optional accepted-trigger counter is compiled in with VERINJECT_FF_SEU_COUNT_EN.
module verinject_ff_injector_seu #(
  parameter int          LEFT        = 0,
  parameter int          RIGHT       = 0,
  parameter int unsigned P_START     = 0,
  parameter int          MBU_WIDTH   = 1,
  parameter int          HOLD_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               do_write,
  input  logic [1:0]         mode,
  input  logic [LEFT:RIGHT]  unmodified,
  output logic [LEFT:RIGHT]  modified,
  output logic               fault_active,
  input  logic [31:0]        verinject__injector_state
`ifdef VERINJECT_FF_SEU_COUNT_EN
  ,
  output logic [15:0]        inject_count
`endif
);

  localparam int BitsStart = (LEFT < RIGHT) ? LEFT : RIGHT;
  localparam int WordLen   = (LEFT < RIGHT) ? (RIGHT - LEFT + 1) : (LEFT - RIGHT + 1);
  localparam int CntW      = $clog2(HOLD_CYCLES + 1);

  localparam logic [31:0]        RangeLo  = 32'(P_START);
  localparam logic [31:0]        RangeHi  = 32'(P_START + WordLen);
  localparam logic [CntW-1:0]    HoldInit = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0]    HoldLast = CntW'(1);
  // Four spare bits so the shifted run of ones is truncated at the word top, never wrapped.
  localparam logic [WordLen+3:0] MbuOnes  = (WordLen + 4)'((1 << MBU_WIDTH) - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTransient,
    StUpset,
    StStuck
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [WordLen-1:0] mask_q, mask_d;
  logic [CntW-1:0]    hold_q, hold_d;
  logic [31:0]        prev_q;
  logic               fault_active_q;

  logic               in_range;
  logic               trigger;
  logic [31:0]        offset;
  logic [WordLen-1:0] event_mask;

  always_comb begin
    in_range   = (verinject__injector_state >= RangeLo) && (verinject__injector_state < RangeHi);
    trigger    = in_range && (mode != 2'd3) && (verinject__injector_state != prev_q);
    offset     = verinject__injector_state - RangeLo;
    event_mask = WordLen'(MbuOnes << offset);
  end

  always_comb begin
    fsm_d  = fsm_q;
    mask_d = mask_q;
    hold_d = hold_q;
    if (trigger) begin
      if (fsm_q == StStuck) begin
        mask_d = mask_q | event_mask;
      end else begin
        // A write landing with a new trigger drops the old upset but keeps the new event.
        mask_d = (fsm_q == StUpset && do_write) ? event_mask : (mask_q | event_mask);
        unique case (mode)
          2'd0: begin
            fsm_d  = StTransient;
            hold_d = HoldInit;
          end
          2'd1:    fsm_d = StUpset;
          default: fsm_d = StStuck;
        endcase
      end
    end else begin
      unique case (fsm_q)
        StTransient: begin
          if (hold_q == HoldLast) begin
            fsm_d  = StIdle;
            mask_d = '0;
            hold_d = '0;
          end else begin
            hold_d = hold_q - HoldLast;
          end
        end
        StUpset: begin
          if (do_write) begin
            fsm_d  = StIdle;
            mask_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q          <= StIdle;
      mask_q         <= '0;
      hold_q         <= '0;
      prev_q         <= 32'hFFFF_FFFF;
      fault_active_q <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      mask_q         <= mask_d;
      hold_q         <= hold_d;
      prev_q         <= verinject__injector_state;
      fault_active_q <= |mask_d;
    end
  end

  assign fault_active = fault_active_q;

  for (genvar g = 0; g < WordLen; g++) begin : g_xor
    assign modified[BitsStart+g] = unmodified[BitsStart+g] ^ mask_q[g];
  end

`ifdef VERINJECT_FF_SEU_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (trigger && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign inject_count = count_q;
`endif

endmodule

// File: tb/tb_verinject_ff_injector_seu.sv
// Scoreboard bench for verinject_ff_injector_seu: directed scenarios then random traffic,
// checked against a time-based fault-lifetime model.
module tb_verinject_ff_injector_seu;

  localparam int LEFT        = 7;
  localparam int RIGHT       = 0;
  localparam int P_START     = 100;
  localparam int MBU_WIDTH   = 2;
  localparam int HOLD_CYCLES = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        do_write;
  logic [1:0]  mode;
  logic [7:0]  unmodified;
  logic [7:0]  modified;
  logic        fault_active;
  logic [31:0] inj_state;
`ifdef VERINJECT_FF_SEU_COUNT_EN
  logic [15:0] inject_count;
`endif

  verinject_ff_injector_seu #(
    .LEFT        (LEFT),
    .RIGHT       (RIGHT),
    .P_START     (P_START),
    .MBU_WIDTH   (MBU_WIDTH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .do_write                  (do_write),
    .mode                      (mode),
    .unmodified                (unmodified),
    .modified                  (modified),
    .fault_active              (fault_active),
    .verinject__injector_state (inj_state)
`ifdef VERINJECT_FF_SEU_COUNT_EN
    ,
    .inject_count              (inject_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] modv;
    logic       fa;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: a fault kind plus an absolute expiry cycle, rather than a down-counter.
  localparam int KNone = 0, KTrans = 1, KUpset = 2, KStuck = 3;
  int          cyc    = 0;
  logic [7:0]  m_mask = '0;
  int          m_kind = KNone;
  int          m_exp  = 0;
  logic [31:0] m_prev = 32'hFFFF_FFFF;
  int          m_cnt  = 0;

  task automatic model_step(input logic r, input logic [31:0] s, input logic [1:0] md,
                            input logic w);
    logic       trig;
    logic [7:0] ev;
    cyc++;
    if (r) begin
      m_mask = '0;
      m_kind = KNone;
      m_prev = 32'hFFFF_FFFF;
      m_cnt  = 0;
      return;
    end
    trig   = (s >= 32'(P_START)) && (s < 32'(P_START + 8)) && (md != 2'd3) && (s != m_prev);
    m_prev = s;
    ev     = '0;
    if (trig) begin
      for (int k = 0; k < MBU_WIDTH; k++) begin
        int b;
        b = int'(s) - P_START + k;
        if (b < 8) ev[b] = 1'b1;
      end
      if (m_cnt < 65535) m_cnt++;
      if (m_kind == KStuck) begin
        m_mask = m_mask | ev;
      end else begin
        m_mask = (m_kind == KUpset && w) ? ev : (m_mask | ev);
        case (md)
          2'd0: begin
            m_kind = KTrans;
            m_exp  = cyc + HOLD_CYCLES;
          end
          2'd1:    m_kind = KUpset;
          default: m_kind = KStuck;
        endcase
      end
    end else if ((m_kind == KTrans && cyc == m_exp) || (m_kind == KUpset && w)) begin
      m_mask = '0;
      m_kind = KNone;
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] s, input logic [1:0] md,
                       input logic w, input logic [7:0] u);
    exp_t e;
    @(negedge clock);
    reset      = r;
    inj_state  = s;
    mode       = md;
    do_write   = w;
    unmodified = u;
    model_step(r, s, md, w);
    e.cyc  = cyc;
    e.modv = u ^ m_mask;
    e.fa   = (m_mask != 0);
    e.cnt  = 16'(m_cnt);
    q.push_back(e);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (modified !== e.modv) begin
        n_fail++;
        $display("FAIL modified step=%0d got=%h exp=%h", e.cyc, modified, e.modv);
      end
      n_tests++;
      if (fault_active !== e.fa) begin
        n_fail++;
        $display("FAIL fault_active step=%0d got=%b exp=%b", e.cyc, fault_active, e.fa);
      end
`ifdef VERINJECT_FF_SEU_COUNT_EN
      n_tests++;
      if (inject_count !== e.cnt) begin
        n_fail++;
        $display("FAIL inject_count step=%0d got=%0d exp=%0d", e.cyc, inject_count, e.cnt);
      end
`endif
    end
  end

  task automatic idle(input int n, input logic [31:0] s);
    for (int i = 0; i < n; i++) drive(1'b0, s, 2'd0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] last_s;
    reset      = 1'b1;
    do_write   = 1'b0;
    mode       = 2'd0;
    inj_state  = 32'd0;
    unmodified = 8'h00;

    drive(1'b1, 0, 2'd0, 1'b0, 8'h00);
    drive(1'b1, 0, 2'd0, 1'b0, 8'h00);
    idle(3, 0);
    // Transient at 103
    drive(1'b0, 103, 2'd0, 1'b0, 8'h00);
    idle(5, 0);
    // Top-edge truncation, held as upset then cleared
    drive(1'b0, 107, 2'd1, 1'b0, 8'h00);
    idle(2, 0);
    drive(1'b0, 0, 2'd0, 1'b1, 8'h00);
    idle(2, 0);
    // Out of range
    drive(1'b0, 99, 2'd1, 1'b0, 8'h00);
    drive(1'b0, 108, 2'd1, 1'b0, 8'h00);
    idle(2, 0);
    // Held state triggers once
    for (int i = 0; i < 10; i++) drive(1'b0, 102, 2'd0, 1'b0, 8'h00);
    idle(2, 0);
    // Upset persists, write clears, simultaneous trigger and write
    drive(1'b0, 101, 2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) drive(1'b0, 101, 2'd1, 1'b0, 8'h00);
    drive(1'b0, 0, 2'd0, 1'b1, 8'h00);
    idle(2, 0);
    drive(1'b0, 101, 2'd1, 1'b0, 8'h00);
    drive(1'b0, 104, 2'd1, 1'b1, 8'h00);
    idle(2, 0);
    drive(1'b0, 0, 2'd0, 1'b1, 8'h00);
    // Stuck absorbs a later mode-0 trigger and ignores writes
    drive(1'b0, 100, 2'd2, 1'b0, 8'h00);
    drive(1'b0, 105, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 2'd0, i[0], 8'h00);
    drive(1'b1, 0, 2'd0, 1'b0, 8'h00);
    idle(2, 0);
    // Reset in the second active cycle of a transient
    drive(1'b0, 103, 2'd0, 1'b0, 8'h00);
    drive(1'b1, 0, 2'd0, 1'b0, 8'h00);
    idle(2, 0);
    // Disabled mode
    drive(1'b0, 102, 2'd3, 1'b0, 8'h00);
    idle(3, 102);
    idle(2, 0);
    // Combinational pass-through with a live mask
    drive(1'b0, 106, 2'd1, 1'b0, 8'hA5);
    drive(1'b0, 0, 2'd0, 1'b0, 8'h3C);
    drive(1'b0, 0, 2'd0, 1'b1, 8'hFF);

    last_s = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       s = 32'($urandom_range(96, 111));
      else if (r < 9)  s = last_s;
      else             s = $urandom;
      last_s = s;
      drive(($urandom_range(0, 49) == 0), s, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    @(posedge clock);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
